// File: rtl/cpu_mult_pkg.sv
// cpu_mult_pkg: shared types and constants for the sequential multiplier.
//   mult_state_t : control FSM states (IDLE / RUN / DONE)
//   MULT_W       : operand width, fixed to match the 16-bit CLA adder
//   MULT_ITERS   : shift-and-add iterations per multiply
//   MULT_CNT_W   : width of the iteration counter
package cpu_mult_pkg;

    localparam int unsigned MULT_W     = 16;
    localparam int unsigned MULT_ITERS = 16;
    localparam int unsigned MULT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mult_state_t;

endpackage

// File: rtl/seq_mult_16_if.sv
// seq_mult_16_if: request/response bundle between the control unit and the
// sequential multiplier.
//   start   : request, honoured only while ready=1
//   a, b    : multiplicand / multiplier, captured on the accepted start
//   ready   : multiplier idle and able to accept start
//   busy    : iterating
//   done    : one-cycle pulse, product valid
//   product : 32-bit result, held until the next completion
// master = requester (control unit), slave = multiplier.
interface seq_mult_16_if;
    import cpu_mult_pkg::*;

    logic                  start;
    logic [MULT_W-1:0]     a;
    logic [MULT_W-1:0]     b;
    logic                  ready;
    logic                  busy;
    logic                  done;
    logic [2*MULT_W-1:0]   product;

    modport master (
        output start, a, b,
        input  ready, busy, done, product
    );

    modport slave (
        input  start, a, b,
        output ready, busy, done, product
    );

endinterface

// File: rtl/alt_CLA_5_5_6_adder.sv
// alt_CLA_5_5_6_adder: 16-bit carry-lookahead adder split into groups of
// 5, 5 and 6 bits. Group generate/propagate terms feed a lookahead stage
// that produces each group's carry-in; bits inside a group ripple from it.
// No carry-out is exposed.
//   a_i, b_i : 16-bit operands
//   cin_i    : carry-in
//   sum_o    : 16-bit sum (modulo 2^16)
module alt_CLA_5_5_6_adder (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] sum_o
);

    logic [15:0] g;
    logic [15:0] p;
    logic        gg0, gg1, gp0, gp1;
    logic        gc1, gc2;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Group generate/propagate for the two lower groups; the top group's
    // terms would only feed a carry-out, which this adder does not provide.
    always_comb begin
        gg0 = 1'b0;
        gp0 = 1'b1;
        gg1 = 1'b0;
        gp1 = 1'b1;
        for (int unsigned i = 0; i < 5; i++) begin
            gg0 = g[i] | (p[i] & gg0);
            gp0 = gp0 & p[i];
        end
        for (int unsigned i = 5; i < 10; i++) begin
            gg1 = g[i] | (p[i] & gg1);
            gp1 = gp1 & p[i];
        end
    end

    assign gc1 = gg0 | (gp0 & cin_i);
    assign gc2 = gg1 | (gp1 & gg0) | (gp1 & gp0 & cin_i);

    always_comb begin
        logic cr;
        sum_o = '0;
        cr    = cin_i;
        for (int unsigned i = 0; i < 16; i++) begin
            if (i == 5)  cr = gc1;
            if (i == 10) cr = gc2;
            sum_o[i] = p[i] ^ cr;
            cr       = g[i] | (p[i] & cr);
        end
    end

endmodule

// File: rtl/seq_mult_16.sv
// seq_mult_16: sequential 16x16 unsigned shift-and-add multiplier.
// One iteration per cycle for 16 cycles, using the shared 5/5/6 CLA adder
// for the partial-product add and rebuilding its missing carry-out here.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of seq_mult_16_if (start/a/b in,
//              ready/busy/done/product out)
module seq_mult_16
    import cpu_mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_W
) (
    input  logic          clk,
    input  logic          rst,
    seq_mult_16_if.slave  bus
);

    localparam logic [MULT_CNT_W-1:0] CNT_LAST = MULT_CNT_W'(MULT_ITERS - 1);

    mult_state_t             state_q;
    logic [WIDTH-1:0]        m_q;
    logic [2*WIDTH-1:0]      p_q;
    logic [2*WIDTH-1:0]      p_d;
    logic [MULT_CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0]      product_q;
    logic                    ready_q;
    logic                    busy_q;
    logic                    done_q;

    logic [WIDTH-1:0]        add_a;
    logic [WIDTH-1:0]        add_s;
    logic                    carry;

    assign add_a = p_q[2*WIDTH-1:WIDTH];

    alt_CLA_5_5_6_adder u_add (
        .a_i   (add_a),
        .b_i   (m_q),
        .cin_i (1'b0),
        .sum_o (add_s)
    );

    // Carry-out recovered from operand MSBs and sum MSB: a carry leaves
    // bit 15 if both MSBs are set, or exactly one is set and the sum MSB
    // dropped to 0.
    assign carry = (add_a[WIDTH-1] & m_q[WIDTH-1])
                 | ((add_a[WIDTH-1] ^ m_q[WIDTH-1]) & ~add_s[WIDTH-1]);

    always_comb begin
        p_d = '0;
        if (p_q[0]) begin
            p_d = {carry, add_s, p_q[WIDTH-1:1]};
        end else begin
            p_d = {1'b0, p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            m_q       <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        m_q     <= bus.a;
                        p_q     <= {{WIDTH{1'b0}}, bus.b};
                        cnt_q   <= '0;
                        state_q <= RUN;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    p_q   <= p_d;
                    cnt_q <= cnt_q + MULT_CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        product_q <= p_d;
                        state_q   <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready   = ready_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;

endmodule

// File: tb/tb_seq_mult_16.sv
// tb_seq_mult_16: self-checking bench for seq_mult_16.
// Table-driven directed multiplies plus hand-written sequences for held
// start, reset mid-run and random operand pairs.
module tb_seq_mult_16;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic prev_done;

    seq_mult_16_if bus ();

    seq_mult_16 #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // done must never stay high on two consecutive cycles
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            checks++;
            if (prev_done === 1'b1) begin
                errors++;
                $display("FAIL done_double: got done=1 twice expected single pulse");
            end
        end
        prev_done = bus.done;
    end

    task automatic wait_ready();
        for (int i = 0; i < 40 && bus.ready !== 1'b1; i++) @(negedge clk);
    endtask

    // Starts one multiply at the current negedge (cycle 0) and follows it to
    // done. With timing=1 also checks the cycle-accurate handshake.
    task automatic run_op(input logic [15:0] va, input logic [15:0] vb,
                          input logic [31:0] exp, input string nm, input bit timing);
        int cyc;
        int busy_cnt;
        bit seen;
        wait_ready();
        bus.start = 1'b1;
        bus.a     = va;
        bus.b     = vb;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 16'hDEAD;
        bus.b     = 16'hBEEF;
        cyc = 1;
        busy_cnt = 0;
        seen = 1'b0;
        while (cyc < 40) begin
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy === 1'b1) busy_cnt++;
            cyc++;
            @(negedge clk);
        end
        chk({nm, " done_seen"}, {31'b0, seen}, 32'd1);
        chk({nm, " product"}, bus.product, exp);
        if (timing) begin
            chk({nm, " done_cycle"}, cyc, 32'd17);
            chk({nm, " busy_cycles"}, busy_cnt, 32'd16);
            chk({nm, " ready_at_done"}, {31'b0, bus.ready}, 32'd0);
            chk({nm, " busy_at_done"}, {31'b0, bus.busy}, 32'd0);
            @(negedge clk);
            chk({nm, " ready_after"}, {31'b0, bus.ready}, 32'd1);
            chk({nm, " product_held"}, bus.product, exp);
        end
    endtask

    initial begin
        vec_t vecs[9];
        int   unexpected;
        logic [15:0] ra, rb;

        errors    = 0;
        checks    = 0;
        prev_done = 1'b0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vecs[2] = '{16'h1234, 16'h0000, 32'h00000000};
        vecs[3] = '{16'h0000, 16'hABCD, 32'h00000000};
        vecs[4] = '{16'h8000, 16'h0002, 32'h00010000};
        vecs[5] = '{16'h0001, 16'hFFFF, 32'h0000FFFF};
        vecs[6] = '{16'hFFFF, 16'h8000, 32'h7FFF8000};
        vecs[7] = '{16'h00FF, 16'h0100, 32'h0000FF00};
        vecs[8] = '{16'h1234, 16'h5678, 32'h06260060};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst ready", {31'b0, bus.ready}, 32'd1);
        chk("rst busy", {31'b0, bus.busy}, 32'd0);
        chk("rst done", {31'b0, bus.done}, 32'd0);
        chk("rst product", bus.product, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i), 1'b1);
        end

        // start held high: DONE-cycle start ignored, next accepted at 18
        wait_ready();
        unexpected = 0;
        bus.start = 1'b1;
        bus.a     = 16'd7;
        bus.b     = 16'd9;
        for (int cyc = 1; cyc <= 35; cyc++) begin
            @(negedge clk);
            if (cyc == 17) begin
                chk("hold done17", {31'b0, bus.done}, 32'd1);
                chk("hold product17", bus.product, 32'd63);
                bus.a = 16'd5;
                bus.b = 16'd5;
            end else if (cyc == 35) begin
                chk("hold done35", {31'b0, bus.done}, 32'd1);
                chk("hold product35", bus.product, 32'd6);
            end else begin
                if (bus.done === 1'b1) unexpected++;
                if (cyc == 1) begin
                    bus.a = 16'hFFFF;
                    bus.b = 16'hFFFF;
                end
                if (cyc == 18) begin
                    chk("hold ready18", {31'b0, bus.ready}, 32'd1);
                    bus.a = 16'd2;
                    bus.b = 16'd3;
                end
                if (cyc == 19) begin
                    chk("hold busy19", {31'b0, bus.busy}, 32'd1);
                    bus.start = 1'b0;
                    bus.a = 16'h5A5A;
                    bus.b = 16'hA5A5;
                end
            end
        end
        chk("hold unexpected_done", unexpected, 32'd0);

        // reset in cycle 8 together with start: aborts and start is dropped
        wait_ready();
        bus.start = 1'b1;
        bus.a     = 16'h1234;
        bus.b     = 16'h5678;
        @(negedge clk);
        bus.start = 1'b0;
        for (int cyc = 2; cyc <= 8; cyc++) @(negedge clk);
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.a     = 16'd3;
        bus.b     = 16'd3;
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        chk("abort ready", {31'b0, bus.ready}, 32'd1);
        chk("abort busy", {31'b0, bus.busy}, 32'd0);
        chk("abort done", {31'b0, bus.done}, 32'd0);
        chk("abort product", bus.product, 32'd0);
        @(negedge clk);
        chk("abort still_idle", {31'b0, bus.busy}, 32'd0);
        run_op(16'd10, 16'd10, 32'd100, "after_reset", 1'b1);

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_op(ra, rb, 32'(ra) * 32'(rb), $sformatf("rand%0d", i), 1'b0);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
